// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 execute stage.
//   - Default datapath and shift-amount widths
//   - 3-bit op code encodings
//   - FSM state encoding used by alu32_stage
package alu32_pkg;

   localparam int unsigned ALU_WIDTH   = 32;
   localparam int unsigned ALU_SHAMT_W = 5;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/alu32_logic.sv
// Combinational single-cycle ALU operations (AND/OR/XOR/NOR/ADD/SUB/SLT).
// Ports:
//   a, b     : operands
//   op       : op code (SRL yields 0 here; the stage handles shifting)
//   result   : operation result
//   overflow : signed overflow, set only for ADD and SUB
module alu32_logic
   import alu32_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             lt;

   assign sum  = a + b;
   assign diff = a - b;

   // Subtraction adds the negated B, whose sign is the inverse of B's sign.
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
   assign lt      = $signed(a) < $signed(b);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      unique case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_NOR: result = ~(a | b);
         OP_ADD: begin
            result   = sum;
            overflow = add_ovf;
         end
         OP_SUB: begin
            result   = diff;
            overflow = sub_ovf;
         end
         OP_SLT: result = {{(WIDTH-1){1'b0}}, lt};
         OP_SRL: result = '0;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/alu32_stage.sv
// Registered 32-bit ALU execute stage with a multi-cycle serial right shift.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid, in_ready    : upstream handshake (in_ready combinational)
//   A, B, op              : operands and op code; B[4:0] is the SRL amount
//   out_valid, out_ready  : downstream handshake
//   res, zero, overflow   : registered result and flags
module alu32_stage
   import alu32_pkg::*;
#(
   parameter int unsigned WIDTH   = ALU_WIDTH,
   parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             overflow
);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     shreg_q, shreg_d;
   logic [SHAMT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 zero_q, zero_d;
   logic                 ovf_q, ovf_d;
   logic                 valid_q, valid_d;

   logic [WIDTH-1:0]     logic_res;
   logic                 logic_ovf;
   logic [SHAMT_W-1:0]   shamt;
   logic                 accept;

   alu32_logic #(
      .WIDTH (WIDTH)
   ) u_logic (
      .a        (A),
      .b        (B),
      .op       (op),
      .result   (logic_res),
      .overflow (logic_ovf)
   );

   assign shamt    = B[SHAMT_W-1:0];
   assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;

      case (state_q)
         IDLE, HOLD: begin
            // Result consumed with nothing new arriving.
            if ((state_q == HOLD) && out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
            if (accept) begin
               if ((op == OP_SRL) && (shamt != '0)) begin
                  shreg_d = A;
                  cnt_d   = shamt;
                  valid_d = 1'b0;
                  state_d = SHIFT;
               end else begin
                  // SRL by zero passes A straight through.
                  res_d   = (op == OP_SRL) ? A : logic_res;
                  ovf_d   = (op == OP_SRL) ? 1'b0 : logic_ovf;
                  zero_d  = (res_d == '0);
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end
         end

         SHIFT: begin
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q - 1'b1;
            // Last shift: publish the shifted value directly.
            if (cnt_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
               res_d   = shreg_q >> 1;
               zero_d  = ((shreg_q >> 1) == '0);
               ovf_d   = 1'b0;
               valid_d = 1'b1;
               state_d = HOLD;
            end
         end

         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign res       = res_q;
   assign zero      = zero_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu32_stage.sv
// Self-checking bench for alu32_stage: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu32_stage;
   import alu32_pkg::*;

   localparam longint MAX_S = 64'sd2147483647;
   localparam longint MIN_S = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [2:0]  op = '0;
   logic        in_ready;
   logic        out_valid;
   logic        zero;
   logic        overflow;
   logic [31:0] res;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   alu32_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .zero      (zero),
      .overflow  (overflow)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: plain integer arithmetic on the op's meaning.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic v);
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      v  = 1'b0;
      r  = '0;
      case (o)
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOR: r = ~(a | b);
         OP_SRL: r = a >> b[4:0];
         OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
         OP_ADD: begin
            s = sa + sb;
            r = 32'(s);
            v = (s > MAX_S) || (s < MIN_S);
         end
         OP_SUB: begin
            s = sa - sb;
            r = 32'(s);
            v = (s > MAX_S) || (s < MIN_S);
         end
         default: r = '0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op and hold it until accepted (bounded).
   task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      op = o; A = a; B = b; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      checks++; if (res !== 32'h0) begin fails++; $display("FAIL rst_res: got %h required 00000000", res); end
      checks++; if (zero !== 1'b0) begin fails++; $display("FAIL rst_zero: got %b required 0", zero); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b required 0", overflow); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_or();
      out_ready = 1'b1;
      send(OP_OR, 32'h0000FFFF, 32'h00FF00FF);
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL or_valid: got %b required 1", out_valid); end
      checks++; if (res !== 32'h00FFFFFF) begin fails++; $display("FAIL or_res: got %h required 00ffffff", res); end
      checks++; if (zero !== 1'b0) begin fails++; $display("FAIL or_zero: got %b required 0", zero); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL or_overflow: got %b required 0", overflow); end
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL or_valid_drop: got %b required 0", out_valid); end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op [5] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLT, OP_NOR};
      logic [31:0] t_a  [5] = '{32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h00000001, 32'h0};
      logic [31:0] t_b  [5] = '{32'h00000001, 32'h12345678, 32'h00000001, 32'hFFFFFFFF, 32'h0};
      logic [31:0] t_r  [5] = '{32'h80000000, 32'h0, 32'h00000001, 32'h0, 32'hFFFFFFFF};
      logic        t_z  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        t_v  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(t_op[i], t_a[i], t_b[i]);
         checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL dir%0d_valid: got %b required 1", i, out_valid); end
         checks++; if (res !== t_r[i]) begin fails++; $display("FAIL dir%0d_res: got %h required %h", i, res, t_r[i]); end
         checks++; if (zero !== t_z[i]) begin fails++; $display("FAIL dir%0d_zero: got %b required %b", i, zero, t_z[i]); end
         checks++; if (overflow !== t_v[i]) begin fails++; $display("FAIL dir%0d_ovf: got %b required %b", i, overflow, t_v[i]); end
      end
      tick();
   endtask

   task automatic test_srl();
      out_ready = 1'b1;
      send(OP_SRL, 32'h80000000, 32'd4);
      // Operand changes after accept must not disturb the shift.
      A = 32'h0; B = 32'hFFFFFFFF; op = OP_AND;
      for (int i = 0; i < 4; i++) begin
         checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL srl_busy%0d: in_ready got %b required 0", i, in_ready); end
         checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL srl_early%0d: out_valid got %b required 0", i, out_valid); end
         tick();
      end
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL srl_valid: got %b required 1", out_valid); end
      checks++; if (res !== 32'h08000000) begin fails++; $display("FAIL srl_res: got %h required 08000000", res); end
      tick();
      send(OP_SRL, 32'hDEADBEEF, 32'h20);
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL srl0_valid: got %b required 1", out_valid); end
      checks++; if (res !== 32'hDEADBEEF) begin fails++; $display("FAIL srl0_res: got %h required deadbeef", res); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
      // Next op waits upstream; it must not be taken while stalled.
      op = OP_XOR; A = 32'h12345678; B = 32'h0F0F0F0F; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid%0d: got %b required 1", i, out_valid); end
         checks++; if (res !== 32'hF000F000) begin fails++; $display("FAIL bp_res%0d: got %h required f000f000", i, res); end
         checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d: got %b required 0", i, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b required 1", out_valid); end
      checks++; if (res !== 32'h1D3B5977) begin fails++; $display("FAIL b2b_res: got %h required 1d3b5977", res); end
      tick();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b required 0", out_valid); end
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b, r;
      logic        v;
      int          n, lat;
      out_ready = 1'b1;
      for (int it = 0; it < 150; it++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         model(o, a, b, r, v);
         lat = (o == OP_SRL) ? int'(b[4:0]) : 0;
         send(o, a, b);
         n = 0;
         while (!out_valid && n < 40) begin
            tick();
            n++;
         end
         checks++; if (n !== lat) begin fails++; $display("FAIL rnd%0d_latency: got %0d required %0d (op %0d)", it, n, lat, o); end
         checks++; if (res !== r) begin fails++; $display("FAIL rnd%0d_res: got %h required %h (op %0d a %h b %h)", it, res, r, o, a, b); end
         checks++; if (zero !== (r == 32'h0)) begin fails++; $display("FAIL rnd%0d_zero: got %b required %b", it, zero, (r == 32'h0)); end
         checks++; if (overflow !== v) begin fails++; $display("FAIL rnd%0d_ovf: got %b required %b (op %0d a %h b %h)", it, overflow, v, o, a, b); end
         if ($urandom_range(0, 4) == 0) tick();
      end
      tick();
   endtask

   task automatic test_reset_mid_shift();
      out_ready = 1'b1;
      send(OP_OR, 32'h1, 32'h0);
      checks++; if (res !== 32'h1) begin fails++; $display("FAIL pre_rst_res: got %h required 00000001", res); end
      send(OP_SRL, 32'hFFFFFFFF, 32'd10);
      tick();
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
      checks++; if (res !== 32'h0) begin fails++; $display("FAIL midrst_res: got %h required 00000000", res); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b required 1", in_ready); end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stale%0d: out_valid got %b required 0", i, out_valid); end
      end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL postrst_ready: got %b required 1", in_ready); end
      send(OP_ADD, 32'd5, 32'd7);
      checks++; if (res !== 32'd12) begin fails++; $display("FAIL postrst_res: got %h required 0000000c", res); end
      tick();
   endtask

   initial begin
      test_reset();
      test_or();
      test_directed();
      test_srl();
      test_backpressure();
      test_random();
      test_reset_mid_shift();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
